// File: rtl/five_dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package five_dmem_arbiter_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/five_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module five_arb_pick
  import five_dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner
);

`ifdef DMEM_ARB_RR_EN
`else
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;
`endif

  // Tie resolution; a lone requester always wins.
  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      winner = ~last_owner;
`else
      winner = PORT_CPU;
`endif
    end else if (req1) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/five_dmem_arbiter.sv
// Arbiter sharing the single-ported data memory between the CPU (port 0) and debug loader (port 1).
// Tie policy is set by DMEM_ARB_RR_EN (round-robin when defined, port 0 priority otherwise).
module five_dmem_arbiter
  import five_dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          owner,
  output logic          wr_dmemory,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] in_dmemory,
  input  logic [DW-1:0] out_dmemory
);

  arb_state_e    state_r;
  arb_state_e    state_s;
  logic          owner_r;
  logic          win_s;
  logic          sel_we_s;
  logic          ack0_r;
  logic          ack1_r;
  logic          busy_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

  five_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (owner_r),
    .winner     (win_s)
  );

  assign sel_we_s = (owner_r == PORT_DBG) ? we1 : we0;

  // Next-state logic; DONE never looks at requests.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          state_s = SERVE;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory-side mux; the write strobe is suppressed while reset is asserted.
  always_comb begin
    wr_dmemory = 1'b0;
    Addr       = {AW{1'b0}};
    in_dmemory = {DW{1'b0}};
    if (state_r == SERVE) begin
      wr_dmemory = sel_we_s & ~rst;
      Addr       = (owner_r == PORT_DBG) ? addr1 : addr0;
      in_dmemory = (owner_r == PORT_DBG) ? wdata1 : wdata0;
    end else begin
      wr_dmemory = 1'b0;
    end
  end

  // State, owner, acknowledge and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= PORT_DBG;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
      rdata0_r <= {DW{1'b0}};
      rdata1_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      ack0_r  <= (state_r == SERVE) && (owner_r == PORT_CPU);
      ack1_r  <= (state_r == SERVE) && (owner_r == PORT_DBG);
      if ((state_r == IDLE) && (req0 || req1)) begin
        owner_r <= win_s;
      end
      if ((state_r == SERVE) && !sel_we_s) begin
        if (owner_r == PORT_DBG) begin
          rdata1_r <= out_dmemory;
        end else begin
          rdata0_r <= out_dmemory;
        end
      end
    end
  end

  assign ack0   = ack0_r;
  assign ack1   = ack1_r;
  assign busy   = busy_r;
  assign owner  = owner_r;
  assign rdata0 = rdata0_r;
  assign rdata1 = rdata1_r;

endmodule

// File: tb/tb_five_dmem_arbiter.sv
// Self-checking bench for five_dmem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-timing model (grant edge g: access after g, ack after g+1).
module tb_five_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = 12'h000, addr1 = 12'h000;
  logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000;
  logic        ack0, ack1, busy, owner, wr_dmemory;
  logic [15:0] rdata0, rdata1, in_dmemory, out_dmemory;
  logic [11:0] Addr;

  five_dmem_arbiter #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .owner(owner), .wr_dmemory(wr_dmemory), .Addr(Addr),
    .in_dmemory(in_dmemory), .out_dmemory(out_dmemory)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [15:0] mem [0:4095];
  assign out_dmemory = mem[Addr];
  always @(posedge clk) if (wr_dmemory) mem[Addr] <= in_dmemory;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction level, keyed on the edge number of the last grant.
  logic [15:0] mmem [0:4095];
  int          e = 0;
  int          g = -100;
  bit          m_last = 1'b1;
  bit          m_port = 1'b0;
  bit          m_we = 1'b0;
  logic [11:0] m_addr = 12'h000;
  logic [15:0] m_wd = 16'h0000;
  logic [15:0] m_rd0 = 16'h0000, m_rd1 = 16'h0000;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = 16'h0000;
      mmem[i] = 16'h0000;
    end
    mem[0] = 16'h0002; mem[1] = 16'h4df8; mem[2] = 16'h0003;
    mmem[0] = 16'h0002; mmem[1] = 16'h4df8; mmem[2] = 16'h0003;
  end

  initial forever begin
    @(posedge clk);
    e++;
    if (rst) begin
      g = -100; m_last = 1'b1; m_rd0 = 16'h0000; m_rd1 = 16'h0000;
    end else if (e == g + 1) begin
      if (m_we) mmem[m_addr] = m_wd;
      else if (m_port) m_rd1 = mmem[m_addr];
      else m_rd0 = mmem[m_addr];
    end else if (e >= g + 3 && (req0 || req1)) begin
      if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
        m_port = !m_last;
`else
        m_port = 1'b0;
`endif
      end else begin
        m_port = req1;
      end
      m_we   = m_port ? we1 : we0;
      m_addr = m_port ? addr1 : addr0;
      m_wd   = m_port ? wdata1 : wdata0;
      m_last = m_port;
      g      = e;
    end
  end

  // Per-cycle compare against the model.
  int rel;
  bit sv, dn;
  initial forever begin
    @(negedge clk);
    if (e > 0) begin
      rel = e - g;
      sv  = (rel == 0);
      dn  = (rel == 1);
      chk("ack0", 32'(ack0), 32'(dn && !m_port));
      chk("ack1", 32'(ack1), 32'(dn && m_port));
      chk("busy", 32'(busy), 32'(sv || dn));
      chk("owner", 32'(owner), 32'(m_last));
      chk("wr_dmemory", 32'(wr_dmemory), 32'(sv && m_we && !rst));
      chk("Addr", 32'(Addr), sv ? 32'(m_addr) : 32'd0);
      chk("in_dmemory", 32'(in_dmemory), sv ? 32'(m_wd) : 32'd0);
      chk("rdata0", 32'(rdata0), 32'(m_rd0));
      chk("rdata1", 32'(rdata1), 32'(m_rd1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One complete transaction on a port; returns read data seen with the ack.
  task automatic do_op(input bit p, input bit w, input logic [11:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output bit acked, output bit wr_seen);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    tick();
    wr_seen = wr_dmemory;
    tick();
    acked = p ? ack1 : ack0;
    rd    = p ? rdata1 : rdata0;
    tick();
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic new_req(input bit p);
    logic [11:0] a;
    a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
    if (p) begin req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = a; wdata1 = 16'($urandom); end
    else   begin req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = a; wdata0 = 16'($urandom); end
  endtask

  logic [15:0] rd;
  bit          ok, wrs;
  int          order [6];
  int          n;
  bit          dp0, dp1;

  initial begin
    do_reset();
    chk("reset_owner", 32'(owner), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata0", 32'(rdata0), 32'd0);

    // Single read on port 0.
    do_op(1'b0, 1'b0, 12'h001, 16'h0000, rd, ok, wrs);
    chk("single_ack0", 32'(ok), 32'd1);
    chk("single_rdata0", 32'(rd), 32'h4df8);
    chk("single_no_wr", 32'(wrs), 32'd0);

    // Write then read on port 1 at the top address.
    do_op(1'b1, 1'b1, 12'hFFF, 16'h1234, rd, ok, wrs);
    chk("wr_strobe", 32'(wrs), 32'd1);
    chk("wr_ack1", 32'(ok), 32'd1);
    do_op(1'b1, 1'b0, 12'hFFF, 16'h0000, rd, ok, wrs);
    chk("rd_back_fff", 32'(rd), 32'h1234);
    chk("mem_fff", 32'(mem[12'hFFF]), 32'h1234);

    // Tie after reset: port 0 first, port 1 three cycles later.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h002;
    tick(); tick();
    chk("tie_ack0", 32'(ack0), 32'd1);
    chk("tie_ack1_lo", 32'(ack1), 32'd0);
    chk("tie_rdata0", 32'(rdata0), 32'h0002);
    tick(); req0 = 1'b0;
    tick(); tick();
    chk("tie_ack1", 32'(ack1), 32'd1);
    chk("tie_rdata1", 32'(rdata1), 32'h0003);
    tick(); req1 = 1'b0;

    // Saturation: both ports keep requesting.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h002;
    n = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (n < 6 && ack0) begin order[n] = 0; n++; end
      if (n < 6 && ack1) begin order[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("sat_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk("sat_order", 32'(order[i]), 32'(i % 2));
`else
      chk("sat_order", 32'(order[i]), 32'd0);
`endif
    end
    tick(); tick();

    // Reset during the SERVE cycle of a write.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h002; wdata0 = 16'hBEEF;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_wr_gated", 32'(wr_dmemory), 32'd0);
    tick();
    chk("midrst_ack0", 32'(ack0), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd1);
    rst = 1'b0; req0 = 1'b0;
    tick();
    do_op(1'b0, 1'b0, 12'h002, 16'h0000, rd, ok, wrs);
    chk("midrst_mem2", 32'(rd), 32'h0003);

    // Back-to-back: req0 stays high across DONE with a new address.
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h001;
    tick(); tick();
    chk("b2b_ack0", 32'(ack0), 32'd1);
    tick();
    addr0 = 12'h002;
    chk("b2b_idle", 32'(busy), 32'd0);
    tick();
    chk("b2b_grant", 32'(busy), 32'd1);
    chk("b2b_addr", 32'(Addr), 32'h002);
    tick(); tick();
    req0 = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    dp0 = 1'b0; dp1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dp0 = 1'b0; dp1 = 1'b0;
        continue;
      end
      if (dp0) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b0); else req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        new_req(1'b0);
      end
      if (dp1) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b1); else req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        new_req(1'b1);
      end
      dp0 = ack0;
      dp1 = ack1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/five_dmem_arbiter.md
# five_dmem_arbiter

Two-port arbiter that shares the single-ported 4K×16 data memory between the CPU load/store path (port 0) and the debug/program loader (port 1). It accepts one request per port through a req/ack handshake and runs one transaction at a time. It drives the memory's write enable, address and write data, and registers read data back to the winning requester. It sits between the requesters and the data memory in the top level.

## Interface
Parameters:
- AW, 12: address width, matches the data memory.
- DW, 16: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  AW  word address; stable while req is high.
- wdata0 / wdata1  in  DW  write data; stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DW  registered read data; valid while ack is high, held until the next read on that port.
- busy  out  1  high in SERVE and DONE.
- owner  out  1  port currently or last served.
- wr_dmemory  out  1  memory write enable.
- Addr  out  AW  memory address.
- in_dmemory  out  DW  memory write data.
- out_dmemory  in  DW  memory read data (combinational from Addr).

## Operation
- FSM states: IDLE, SERVE, DONE; a 1-bit register holds the selected port.
- IDLE:
  - No req: stay in IDLE.
  - Any req high: select a winner by the priority rule, latch owner, go to SERVE.
- SERVE:
  - Addr = addr[owner]; in_dmemory = wdata[owner].
  - wr_dmemory = we[owner].
  - On the closing edge: a write commits to memory; a read latches out_dmemory into rdata[owner].
  - Next state: DONE.
- DONE:
  - ack[owner] = 1; all requests are ignored.
  - Next state: IDLE. The requester drops req in the cycle after ack.
- Outside SERVE: wr_dmemory = 0, Addr = 0, in_dmemory = 0.
- Priority with the macro defined: round-robin. When both ports request, the winner is the port not served last. A single requester always wins.
- Both ports always see the same memory contents; there is no address translation or width conversion.

## Timing
- Reset values:
  - State IDLE; owner = 1, so port 0 wins the first tie.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0.
  - wr_dmemory = 0, Addr = 0, in_dmemory = 0.
- Latency: req sampled high at edge N → memory access during cycle N+1 → ack in cycle N+2. Next grant is possible at edge N+3.
- Throughput: one transaction per 3 cycles.
- Simultaneous req0 and req1 in IDLE: exactly one is granted. The loser stays pending and is served immediately after.
- Reset asserted in SERVE: wr_dmemory is gated low that cycle (no write), no ack is issued, and the FSM returns to IDLE.
- A req deasserted before its ack is a protocol violation. The transaction still completes with an ack.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin priority as described above.
- DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins a tie; port 1 is served only when req0 is low in IDLE. owner is still tracked for rdata routing.

## Structure
- Shared package holds:
  - AW and DW defaults.
  - State encoding constants: IDLE = 2'd0, SERVE = 2'd1, DONE = 2'd2.
  - Port index constants: PORT_CPU = 1'b0, PORT_DBG = 1'b1.
- One sub-module, five_arb_pick: combinational winner selection from req0, req1 and the last owner. It contains the DMEM_ARB_RR_EN conditional.
- FSM, muxes and rdata registers live in five_dmem_arbiter.

## Test plan
Test setup: arbiter connected to the data memory, which is preloaded with addr 0 = 0x0002, 1 = 0x4df8, 2 = 0x0003.
- Single read: req0 read addr 1 → ack0 two cycles after sampling; rdata0 = 0x4df8; wr_dmemory never high.
- Write then read: req1 write 0x1234 to addr 0x0FFF, then req1 read addr 0x0FFF → rdata1 = 0x1234. wr_dmemory high for exactly one cycle, with Addr = 0x0FFF.
- Tie after reset: req0 read addr 0 and req1 read addr 2, both asserted at once.
  - ack0 first with rdata0 = 0x0002.
  - ack1 three cycles later with rdata1 = 0x0003.
- Round-robin under saturation (RR_EN defined): both ports request continuously for 6 transactions → acks alternate 0,1,0,1,0,1. With the macro undefined, port 0 is served every time port 1 competes.
- Reset mid-write: req0 write 0xBEEF to addr 2; rst asserted in the SERVE cycle → addr 2 still reads 0x0003, no ack0, all outputs at reset values.
- Back-to-back: req0 held high after ack0 with new addr 2 → DONE ignores it; the second grant occurs at the following IDLE edge.
